// File: rtl/fifo_uart_pkg.sv
// Shared constants and state encoding for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   localparam int unsigned DEF_DATA_WIDTH   = 32;
   localparam int unsigned DEF_CLKS_PER_BIT = 16;
   localparam int unsigned BITS_PER_BYTE    = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CAPTURE = 3'd2,
      START   = 3'd3,
      DATA    = 3'd4,
      STOP    = 3'd5
   } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Per-bit tick generator: counts 0..CLKS_PER_BIT-1 and wraps; tick_c marks the last cycle of a bit.
module uart_baud_tick
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick_c
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt;

   assign tick_c = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls words from a synchronous FIFO and serialises them byte 0 first as 8N1 UART frames.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_cs,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy
);

   localparam int unsigned NUM_BYTES = DATA_WIDTH / BITS_PER_BYTE;
   localparam int unsigned BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int unsigned BIT_W     = $clog2(BITS_PER_BYTE);

   state_t                   state, state_next;
   logic [BIT_W-1:0]         bit_idx, bit_next;
   logic [BYTE_W-1:0]        byte_idx, byte_next;
   logic [DATA_WIDTH-1:0]    word, word_next;
   logic                     tx_next, busy_next, rd_next;
   logic                     tick_c, tick_clear_c;
   logic [BITS_PER_BYTE-1:0] cur_byte_c;

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tick_clear_c),
      .tick_c (tick_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_idx    <= '0;
         byte_idx   <= '0;
         word       <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         fifo_cs    <= 1'b0;
         fifo_rd_en <= 1'b0;
      end else begin
         state      <= state_next;
         bit_idx    <= bit_next;
         byte_idx   <= byte_next;
         word       <= word_next;
         tx         <= tx_next;
         busy       <= busy_next;
         fifo_cs    <= rd_next;
         fifo_rd_en <= rd_next;
      end
   end

   // Next state and counters; outputs are derived from the next state so they register cleanly.
   always_comb begin
      state_next   = state;
      bit_next     = bit_idx;
      byte_next    = byte_idx;
      word_next    = word;
      cur_byte_c   = '0;
      tx_next      = 1'b1;
      busy_next    = 1'b0;
      rd_next      = 1'b0;
      tick_clear_c = 1'b0;

      case (state)
         IDLE: begin
            if (!fifo_empty) state_next = READ;
         end
         READ: begin
            state_next = CAPTURE;
         end
         CAPTURE: begin
            word_next  = fifo_data;
            byte_next  = '0;
            bit_next   = '0;
            state_next = START;
         end
         START: begin
            if (tick_c) begin
               bit_next   = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (tick_c) begin
               if (bit_idx == BIT_W'(BITS_PER_BYTE - 1)) state_next = STOP;
               else                                      bit_next   = bit_idx + BIT_W'(1);
            end
         end
         STOP: begin
            // fifo_empty is only consulted here, at the end of the last byte
            if (tick_c) begin
               if (byte_idx != BYTE_W'(NUM_BYTES - 1)) begin
                  byte_next  = byte_idx + BYTE_W'(1);
                  state_next = START;
               end else if (!fifo_empty) begin
                  state_next = READ;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
         if (byte_next == BYTE_W'(i)) cur_byte_c = word_next[i*BITS_PER_BYTE +: BITS_PER_BYTE];
      end

      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = cur_byte_c[bit_next];
         default: tx_next = 1'b1;
      endcase

      busy_next    = (state_next != IDLE);
      rd_next      = (state_next == READ);
      tick_clear_c = (state_next == START) ? (state != START) : !(state_next inside {DATA, STOP});
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench: fifo_uart_tx fed by an 8-deep synchronous FIFO model, tx decoded by a UART receiver model.
module tb_fifo_uart_tx;

   localparam int unsigned DW  = 32;
   localparam int unsigned CPB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          f_rst_n;
   logic          fifo_empty, fifo_full;
   logic [DW-1:0] fifo_data;
   logic          fifo_cs, fifo_rd_en, tx, busy;
   logic          wr_en;
   logic [DW-1:0] wr_data;

   int vectors    = 0;
   int miscompares = 0;

   fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_cs    (fifo_cs),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Synchronous FIFO model, depth 8; writes while full are dropped
   logic [DW-1:0] fmem [8];
   logic [2:0]    wp, rp;
   logic [3:0]    fcnt;
   logic          do_wr, do_rd;

   assign do_wr      = wr_en && (fcnt != 4'd8);
   assign do_rd      = fifo_rd_en && fifo_cs && (fcnt != 4'd0);
   assign fifo_empty = (fcnt == 4'd0);
   assign fifo_full  = (fcnt == 4'd8);

   always @(posedge clk or negedge f_rst_n) begin
      if (!f_rst_n) begin
         wp        <= 3'd0;
         rp        <= 3'd0;
         fcnt      <= 4'd0;
         fifo_data <= '0;
      end else begin
         if (do_wr) begin
            fmem[wp] <= wr_data;
            wp       <= wp + 3'd1;
         end
         if (do_rd) begin
            fifo_data <= fmem[rp];
            rp        <= rp + 3'd1;
         end
         fcnt <= fcnt + {3'b000, do_wr} - {3'b000, do_rd};
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_q [$];
   int         rd_times [$];
   int         cyc = 0;
   int         tx_low = 0;
   int         frame_len = 0;
   int         frame_start = 0;
   bit         in_frame = 1'b0;
   bit         prev_rd = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Read-strobe and frame monitor
   always @(negedge clk) begin
      if (tx == 1'b0) tx_low++;
      if (fifo_rd_en) begin
         rd_times.push_back(cyc);
         check_val("rd_nonempty", 32'(fifo_empty), 32'd0);
         check_val("rd_cs", 32'(fifo_cs), 32'd1);
         check_val("rd_width", 32'(prev_rd), 32'd0);
      end
      prev_rd = fifo_rd_en;
      if (!in_frame && busy && tx == 1'b0) begin
         in_frame    = 1'b1;
         frame_start = cyc;
      end else if (in_frame && !busy) begin
         frame_len = cyc - frame_start;
         in_frame  = 1'b0;
      end
   end

   // UART receiver model: samples mid-bit, aborts on reset
   bit         rx_on = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (tx == 1'b0) begin
            rx_on  = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % CPB == CPB / 2) begin
            if (rx_cnt / CPB == 0) begin
               check_val("rx_start", 32'(tx), 32'd0);
            end else if (rx_cnt / CPB <= 8) begin
               rx_sh[rx_cnt / CPB - 1] = tx;
            end else begin
               check_val("rx_stop", 32'(tx), 32'd1);
               check_val("rx_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) check_val("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
               rx_on = 1'b0;
            end
         end
      end
   end

   task automatic push_bytes(input logic [DW-1:0] w);
      for (int b = 0; b < 4; b++) exp_q.push_back(w[b*8 +: 8]);
   endtask

   // One write per cycle; expectation pushed only if the FIFO will accept it
   task automatic write_word(input logic [DW-1:0] w, input bit expect_all);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = w;
      if (!fifo_full && expect_all) push_bytes(w);
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      repeat (3) @(negedge clk);
      #1;
      while (!(busy == 1'b0 && fifo_empty && !rx_on) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val("idle_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic wait_rd(input int count, input int budget);
      int n = 0;
      while (rd_times.size() < count && n < budget) begin
         @(posedge clk);
         n++;
      end
      check_val("rd_timeout", 32'(n < budget), 32'd1);
   endtask

   initial begin
      rst_n   = 1'b0;
      f_rst_n = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_tx", 32'(tx), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check_val("rst_cs", 32'(fifo_cs), 32'd0);
      @(negedge clk);
      f_rst_n = 1'b1;
      rst_n   = 1'b1;

      // Idle with empty FIFO
      rd_times.delete();
      tx_low = 0;
      repeat (100) @(negedge clk);
      check_val("idle_rd_pulses", 32'(rd_times.size()), 32'd0);
      check_val("idle_tx_low", 32'(tx_low), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);

      // Single word
      rd_times.delete();
      frame_len = 0;
      write_word(32'h000000A5, 1'b1);
      wait_idle(1000);
      check_val("single_rd_pulses", 32'(rd_times.size()), 32'd1);
      check_val("single_frame_len", 32'(frame_len), 32'd160);
      check_val("single_idle_tx", 32'(tx), 32'd1);

      // Three words back-to-back
      rd_times.delete();
      write_word(32'h11223344, 1'b1);
      write_word(32'hDEADBEEF, 1'b1);
      write_word(32'h00000001, 1'b1);
      wait_idle(2000);
      check_val("b2b_rd_pulses", 32'(rd_times.size()), 32'd3);
      if (rd_times.size() == 3) begin
         check_val("b2b_gap0", 32'(rd_times[1] - rd_times[0]), 32'd162);
         check_val("b2b_gap1", 32'(rd_times[2] - rd_times[1]), 32'd162);
      end

      // Fill FIFO while transmitter is held in reset; the 9th write is dropped
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) write_word(DW'(1) << i, 1'b1);
      @(negedge clk);
      check_val("fill_full", 32'(fifo_full), 32'd1);
      write_word(DW'(1) << 8, 1'b1);
      @(negedge clk);
      check_val("fill_count", 32'(fcnt), 32'd8);
      rd_times.delete();
      rst_n = 1'b1;
      wait_idle(4000);
      check_val("fill_rd_pulses", 32'(rd_times.size()), 32'd8);
      check_val("fill_empty", 32'(fifo_empty), 32'd1);

      // Reset during byte 1 of a word; the next queued word must follow complete
      rd_times.delete();
      write_word(32'hCAFEF00D, 1'b0);
      exp_q.push_back(8'h0D);
      write_word(32'h12345678, 1'b1);
      wait_rd(1, 100);
      repeat (49) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val("abort_tx", 32'(tx), 32'd1);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_rd_en", 32'(fifo_rd_en), 32'd0);
      check_val("abort_cs", 32'(fifo_cs), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_idle(1000);
      check_val("abort_rd_pulses", 32'(rd_times.size()), 32'd2);

      // Word arrives during the last STOP bit of the previous word
      rd_times.delete();
      write_word(32'h5A5AC3C3, 1'b1);
      wait_rd(1, 100);
      repeat (157) @(posedge clk);
      write_word(32'h0F1E2D3C, 1'b1);
      wait_idle(1000);
      check_val("late_rd_pulses", 32'(rd_times.size()), 32'd2);
      if (rd_times.size() == 2) check_val("late_gap", 32'(rd_times[1] - rd_times[0]), 32'd162);

      check_val("rx_missing", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
